hit_recorder: RTL and testbench
===============================

# hit_recorder

Parametrised key-hit capture block for the piano/game datapath. It tracks the current octave and note length and detects note-key presses. Each press becomes a timestamped event `{octave, note, length, time}` queued in an internal FIFO. The playback/scoring logic drains the queue through a valid/ready interface, so no press is lost between its polls. Compared with the single-register capture stage, this block adds edge detection, saturating octave limits, buffering and overflow reporting.

## Interface
Parameters:
- `NOTE_KEYS`, 7, number of note keys; note index width `NW = $clog2(NOTE_KEYS)`
- `LEN_KEYS`, 7, number of length keys; length index width `LW = $clog2(LEN_KEYS)`
- `OCT_MIN`, 1, lowest octave
- `OCT_MAX`, 7, highest octave
- `OCT_RESET`, 4, octave after reset
- `TS_W`, 32, timestamp width
- `DEPTH`, 16, FIFO entries (power of two, ≥2)

Ports:
- `clk` in 1: system clock; one clock, all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `en` in 1: capture enable
- `oct_up`, `oct_down` in 1 each: octave step requests (level inputs, debounced upstream)
- `note_key` in NOTE_KEYS: note keys, level, debounced
- `length_key` in LEN_KEYS: length select keys, level, debounced
- `system_clock` in TS_W: free-running time base
- `octave` out 3: current octave
- `length` out LW: current length index
- `ev_valid` out 1: FIFO head valid
- `ev_ready` in 1: consumer accepts head
- `ev_octave` out 3, `ev_note` out NW, `ev_length` out LW, `ev_time` out TS_W: head event fields
- `count` out $clog2(DEPTH+1): entries held
- `overflow` out 1: sticky, set when an event was dropped
- `clr_ovf` in 1: clears `overflow`

## Operation
- Edge detection: previous-sample registers for `oct_up`, `oct_down`, `note_key` and `length_key` update every cycle, including while `en`=0. An action fires only on a 0→1 transition while `en`=1.
- Octave:
  - Rising `oct_up` increments, saturating at OCT_MAX.
  - Rising `oct_down` decrements, saturating at OCT_MIN.
  - Both rising in the same cycle: no change.
- Length: a rising edge on any `length_key[i]` sets `length`=i. If several rise together, the highest index wins.
- Note: a rising edge on any `note_key[i]` generates one event with `note`=i. If several rise together, the highest index wins and only one event is generated.
- Event contents:
  - `octave` and `length` are the register values before this cycle's update. An octave or length change in the same cycle applies to the next event only.
  - `time` is `system_clock` sampled at that edge.
- `en`=0: no octave or length changes and no new events. State is held, not reset. The FIFO keeps draining normally.
- FIFO:
  - First-word-fall-through; the head is visible on `ev_*` whenever `ev_valid`=1.
  - Pop occurs on `ev_valid & ev_ready`. `ev_ready` is ignored while empty.
  - `ev_*` fields are don't-care while `ev_valid`=0.
- Full FIFO:
  - Push without a pop: the event is dropped, `overflow`←1 and `count` stays at DEPTH.
  - Push with a simultaneous pop: both occur and `count` stays at DEPTH.
- Empty FIFO with push and `ev_ready`=1: the push occurs and there is no pop.
- `overflow` clears on `clr_ovf`=1. If a drop and `clr_ovf` happen in the same cycle, set wins.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `octave`=OCT_RESET, `length`=0, `ev_valid`=0, `count`=0, `overflow`=0. FIFO contents are undefined. Edge registers reset to 0.
- Reset mid-operation flushes queued events.
- A key held high through reset release produces a rising edge on the first cycle after reset.
- Latency:
  - Key sampled high at edge N (low at N−1) → `octave`/`length` update, or event written, at edge N.
  - With an empty FIFO, `ev_valid`=1 and the head is readable right after edge N.
  - `ev_time` equals the `system_clock` value sampled at edge N.
- Throughput: one push and one pop per cycle maximum.
- `count` and `ev_valid` are registered. Outputs have no combinational path from inputs.

## Structure
- Package `hit_pkg`: octave width constant (3), default OCT_MIN/OCT_MAX/OCT_RESET, and the event record layout (field order octave|note|length|time) with its packed width helper.
- Sub-module `hit_fifo`: generic synchronous FWFT FIFO, parameterised in width and depth, with full/empty/count outputs. `hit_recorder` instantiates it with the packed event width.
- Top level contains the edge detectors, priority encoders and octave/length registers.

## Test plan
- Reset, `en`=1, rising `note_key[2]` with `system_clock`=100 → one event {4,2,0,100}; `ev_valid` goes high one edge later; `count`=1.
- Six `oct_up` pulses then three `oct_down` pulses → `octave` reads 5,6,7,7,7,7 then 6,5,4. Then five more `oct_down` pulses → 3,2,1,1,1.
- Same cycle: rising `length_key[3]`, `oct_up` and `note_key[5]`/`note_key[1]` → one event {4,5,0,t}. Next press gives `octave`=5, `length`=3.
- Hold `ev_ready`=0 and generate 17 presses with DEPTH=16 → `count`=16 and `overflow`=1. Draining returns the first 16 events in order. `clr_ovf` then clears the flag.
- Full FIFO with a push and `ev_ready`=1 in the same cycle → `count` stays 16, `overflow` stays 0, and the new event appears last.
- `en`=0 with a key pressed, then `en`=1 while the key is still held → no event. Releasing and re-pressing produces an event. Asserting `rst_n`=0 mid-queue → `ev_valid`=0 and `count`=0 on the next edge.

Source files
------------

// File: rtl/hit_pkg.sv
// Shared constants and event record layout for the key-hit capture path.
// Event records pack MSB-first as octave | note | length | time.
package hit_pkg;

  localparam int OCT_W         = 3;
  localparam int OCT_MIN_DEF   = 1;
  localparam int OCT_MAX_DEF   = 7;
  localparam int OCT_RESET_DEF = 4;

  function automatic int ev_width(input int nw, input int lw, input int ts_w);
    return OCT_W + nw + lw + ts_w;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is always visible on pop_data.
// Storage is not reset, only pointers and occupancy flags.
module hit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             empty_q, full_q;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    cnt_nxt = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt_q + 1'b1;
      2'b01:   cnt_nxt = cnt_q - 1'b1;
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt_q   <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = cnt_q;

endmodule

// File: rtl/hit_recorder.sv
// Key-hit capture: edge-detects octave, length and note keys and queues
// timestamped note events for the playback/scoring consumer.
module hit_recorder import hit_pkg::*; #(
  parameter int NOTE_KEYS = 7,
  parameter int LEN_KEYS  = 7,
  parameter int OCT_MIN   = OCT_MIN_DEF,
  parameter int OCT_MAX   = OCT_MAX_DEF,
  parameter int OCT_RESET = OCT_RESET_DEF,
  parameter int TS_W      = 32,
  parameter int DEPTH     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           oct_up,
  input  logic                           oct_down,
  input  logic [NOTE_KEYS-1:0]           note_key,
  input  logic [LEN_KEYS-1:0]            length_key,
  input  logic [TS_W-1:0]                system_clock,
  output logic [OCT_W-1:0]               octave,
  output logic [$clog2(LEN_KEYS)-1:0]    length,
  output logic                           ev_valid,
  input  logic                           ev_ready,
  output logic [OCT_W-1:0]               ev_octave,
  output logic [$clog2(NOTE_KEYS)-1:0]   ev_note,
  output logic [$clog2(LEN_KEYS)-1:0]    ev_length,
  output logic [TS_W-1:0]                ev_time,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  input  logic                           clr_ovf
);

  localparam int NW = $clog2(NOTE_KEYS);
  localparam int LW = $clog2(LEN_KEYS);
  localparam int EW = ev_width(NW, LW, TS_W);

  function automatic logic [NW-1:0] note_enc(input logic [NOTE_KEYS-1:0] v);
    note_enc = '0;
    for (int i = 0; i < NOTE_KEYS; i++) if (v[i]) note_enc = NW'(i);
  endfunction

  function automatic logic [LW-1:0] len_enc(input logic [LEN_KEYS-1:0] v);
    len_enc = '0;
    for (int i = 0; i < LEN_KEYS; i++) if (v[i]) len_enc = LW'(i);
  endfunction

  function automatic logic [OCT_W-1:0] oct_sat(input logic [OCT_W-1:0] cur,
                                               input logic up, input logic dn);
    oct_sat = cur;
    if (up && !dn && cur < OCT_W'(OCT_MAX))      oct_sat = cur + 1'b1;
    else if (dn && !up && cur > OCT_W'(OCT_MIN)) oct_sat = cur - 1'b1;
  endfunction

  logic                 oct_up_p1, oct_down_p1;
  logic [NOTE_KEYS-1:0] note_key_p1;
  logic [LEN_KEYS-1:0]  length_key_p1;
  logic                 up_rise, dn_rise;
  logic [NOTE_KEYS-1:0] note_rise;
  logic [LEN_KEYS-1:0]  len_rise;
  logic [OCT_W-1:0]     octave_q;
  logic [LW-1:0]        length_q;
  logic                 ovf_q;
  logic                 ev_vld_p0;
  logic [EW-1:0]        ev_data_p0;
  logic [EW-1:0]        head_data;
  logic                 fifo_full, fifo_empty, drop;

  // Stage p1: previous key samples, tracked regardless of en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oct_up_p1     <= 1'b0;
      oct_down_p1   <= 1'b0;
      note_key_p1   <= '0;
      length_key_p1 <= '0;
    end else begin
      oct_up_p1     <= oct_up;
      oct_down_p1   <= oct_down;
      note_key_p1   <= note_key;
      length_key_p1 <= length_key;
    end
  end

  // Stage p0: gated rising edges; the event snapshots octave/length before this cycle's update
  assign up_rise    = en & oct_up   & ~oct_up_p1;
  assign dn_rise    = en & oct_down & ~oct_down_p1;
  assign note_rise  = {NOTE_KEYS{en}} & note_key   & ~note_key_p1;
  assign len_rise   = {LEN_KEYS{en}}  & length_key & ~length_key_p1;
  assign ev_vld_p0  = |note_rise;
  assign ev_data_p0 = {octave_q, note_enc(note_rise), length_q, system_clock};
  assign drop       = ev_vld_p0 & fifo_full & ~ev_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      octave_q <= OCT_W'(OCT_RESET);
      length_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      octave_q <= oct_sat(octave_q, up_rise, dn_rise);
      if (|len_rise) length_q <= len_enc(len_rise);
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  hit_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ev_vld_p0),
    .push_data (ev_data_p0),
    .pop       (ev_ready),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign {ev_octave, ev_note, ev_length, ev_time} = head_data;
  assign ev_valid = ~fifo_empty;
  assign octave   = octave_q;
  assign length   = length_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_hit_recorder.sv
// Directed bench for hit_recorder with the default configuration (7 keys, DEPTH 16).
module tb_hit_recorder;

  logic        clk = 1'b0;
  logic        rst_n, en, oct_up, oct_down, ev_ready, clr_ovf;
  logic [6:0]  note_key, length_key;
  logic [31:0] system_clock;
  logic [2:0]  octave, ev_octave, ev_note, ev_length;
  logic [2:0]  length;
  logic        ev_valid, overflow;
  logic [31:0] ev_time;
  logic [4:0]  count;

  int tests = 0;
  int fails = 0;

  hit_recorder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .oct_up       (oct_up),
    .oct_down     (oct_down),
    .note_key     (note_key),
    .length_key   (length_key),
    .system_clock (system_clock),
    .octave       (octave),
    .length       (length),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_octave    (ev_octave),
    .ev_note      (ev_note),
    .ev_length    (ev_length),
    .ev_time      (ev_time),
    .count        (count),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int n, input int t);
    note_key     = 7'(1 << n);
    system_clock = 32'(t);
    step();
    note_key = '0;
    step();
  endtask

  task automatic pulse_up();
    oct_up = 1'b1; step(); oct_up = 1'b0; step();
  endtask

  task automatic pulse_dn();
    oct_down = 1'b1; step(); oct_down = 1'b0; step();
  endtask

  initial begin
    int up_exp[6];
    int dn_exp[8];
    up_exp = '{5, 6, 7, 7, 7, 7};
    dn_exp = '{6, 5, 4, 3, 2, 1, 1, 1};
    rst_n = 1'b0; en = 1'b0; oct_up = 1'b0; oct_down = 1'b0;
    ev_ready = 1'b0; clr_ovf = 1'b0; note_key = '0; length_key = '0;
    system_clock = '0;
    step(); step();
    chk("rst_octave", octave, 4);
    chk("rst_length", length, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1; step();

    // single press
    en = 1'b1;
    note_key = 7'b0000100; system_clock = 32'd100;
    chk("pre_valid", ev_valid, 0);
    step();
    chk("p1_valid", ev_valid, 1);
    chk("p1_count", count, 1);
    chk("p1_oct", ev_octave, 4);
    chk("p1_note", ev_note, 2);
    chk("p1_len", ev_length, 0);
    chk("p1_time", ev_time, 100);
    note_key = '0; step();
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("p1_drained", count, 0);
    chk("p1_drained_v", ev_valid, 0);

    // octave saturation
    for (int i = 0; i < 6; i++) begin
      oct_up = 1'b1; step();
      chk($sformatf("oct_up%0d", i), octave, up_exp[i]);
      oct_up = 1'b0; step();
    end
    for (int i = 0; i < 8; i++) begin
      oct_down = 1'b1; step();
      chk($sformatf("oct_dn%0d", i), octave, dn_exp[i]);
      oct_down = 1'b0; step();
    end
    oct_up = 1'b1; oct_down = 1'b1; step();
    chk("oct_both", octave, 1);
    oct_up = 1'b0; oct_down = 1'b0; step();
    pulse_up(); pulse_up(); pulse_up();
    chk("oct_back4", octave, 4);

    // simultaneous length/octave/notes
    length_key = 7'b0001000; oct_up = 1'b1; note_key = 7'b0100010;
    system_clock = 32'd200;
    step();
    chk("sim_count", count, 1);
    chk("sim_oct", ev_octave, 4);
    chk("sim_note", ev_note, 5);
    chk("sim_len", ev_length, 0);
    chk("sim_time", ev_time, 200);
    chk("sim_octave_now", octave, 5);
    chk("sim_length_now", length, 3);
    length_key = '0; oct_up = 1'b0; note_key = '0; step();
    press(0, 201);
    chk("sim2_count", count, 2);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("sim2_oct", ev_octave, 5);
    chk("sim2_len", ev_length, 3);
    chk("sim2_note", ev_note, 0);
    chk("sim2_time", ev_time, 201);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("sim2_empty", ev_valid, 0);

    // overflow with 17 presses
    for (int i = 0; i < 17; i++) press(i % 7, 300 + i);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    ev_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_note%0d", i), ev_note, i % 7);
      chk($sformatf("ovf_time%0d", i), ev_time, 300 + i);
      step();
    end
    ev_ready = 1'b0;
    chk("ovf_drained", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // empty FIFO push with ready high: push only
    ev_ready = 1'b1;
    note_key = 7'b0000001; system_clock = 32'd350;
    step();
    chk("emp_push_count", count, 1);
    chk("emp_push_time", ev_time, 350);
    note_key = '0; step();
    ev_ready = 1'b0;
    chk("emp_push_popped", count, 0);

    // full FIFO push with simultaneous pop
    for (int i = 0; i < 16; i++) press(i % 7, 400 + i);
    chk("full_count", count, 16);
    note_key = 7'b1000000; system_clock = 32'd500; ev_ready = 1'b1;
    step();
    ev_ready = 1'b0; note_key = '0;
    chk("fpp_count", count, 16);
    chk("fpp_ovf", overflow, 0);
    chk("fpp_head", ev_time, 401);
    step();
    ev_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("fpp_time%0d", i), ev_time, 401 + i);
      step();
    end
    chk("fpp_last_time", ev_time, 500);
    chk("fpp_last_note", ev_note, 6);
    step();
    ev_ready = 1'b0;
    chk("fpp_empty", ev_valid, 0);

    // enable gating
    en = 1'b0;
    note_key = 7'b0001000; oct_up = 1'b1;
    step(); step();
    chk("en0_count", count, 0);
    chk("en0_oct", octave, 5);
    en = 1'b1; step(); step();
    chk("en1_held", count, 0);
    chk("en1_held_oct", octave, 5);
    note_key = '0; oct_up = 1'b0; step();
    note_key = 7'b0001000; system_clock = 32'd600; step();
    chk("repress_count", count, 1);
    chk("repress_note", ev_note, 3);
    note_key = '0; step();
    press(1, 601);
    chk("pre_rst_count", count, 2);

    // reset mid-queue, key held through release
    rst_n = 1'b0; note_key = 7'b0010000; system_clock = 32'd700;
    step();
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_oct", octave, 4);
    step();
    rst_n = 1'b1; step();
    chk("held_rst_count", count, 1);
    chk("held_rst_note", ev_note, 4);
    chk("held_rst_time", ev_time, 700);
    note_key = '0; step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
